// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: one 1-bit AND/OR/ADD slice reused over WIDTH cycles,
// with operand capture, carry sequencing, result assembly and flag generation.
module serial_alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic             slice_x;
    logic             slice_y;
    logic             slice_sum;
    logic             slice_cout;
    logic             slice_bit;

    // One-bit ALU slice operating on the bit selected by the counter
    always_comb begin
        slice_x    = a_q[cnt_q] ^ op_q[3];
        slice_y    = b_q[cnt_q] ^ op_q[2];
        slice_sum  = slice_x ^ slice_y ^ carry_q;
        slice_cout = (slice_x & slice_y) | (slice_x & carry_q) | (slice_y & carry_q);
        if (op_q[1]) begin
            slice_bit = slice_sum;
        end else if (op_q[0]) begin
            slice_bit = slice_x | slice_y;
        end else begin
            slice_bit = slice_x & slice_y;
        end
    end

    // Next-state, datapath update and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d         = a;
                    b_d         = b;
                    op_d        = alu_op;
                    cnt_d       = '0;
                    // Inverted B pre-loads carry-in of 1 for two's-complement subtract
                    carry_d     = alu_op[2];
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                result_d[cnt_q] = slice_bit;
                carry_d         = slice_cout;
                if (cnt_q == LAST_BIT) begin
                    carry_out_d = slice_cout;
                    overflow_d  = carry_q ^ slice_cout;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
Bit-serial ALU sequencer. It reuses one 1-bit ALU slice (AND/OR/ADD with per-operand invert, carry chained through a register) over WIDTH cycles to compute a full-width result. It is used as the low-area execute unit in the processor's multicycle/pipelined variants. It owns operand capture, bit indexing, carry sequencing, result assembly, flag generation and the start/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH), width of the internal bit counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when ready=1
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
alu_op  input  4  [3]=invert A, [2]=invert B, [1]=select sum, [0]=OR vs AND when [1]=0; sampled on accepted start
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse, result/flags valid
result  output  WIDTH  assembled result, held until next accepted start
zero  output  1  result==0
carry_out  output  1  carry out of MSB slice
overflow  output  1  carry into MSB XOR carry out of MSB

Behaviour:
- Single clock domain, one clock, synchronous active-low reset (reset_n sampled on rising clk edge).
- Reset (reset_n=0 at edge): state=IDLE, counter=0, carry reg=0, operand regs=0, result=0, carry_out=0, overflow=0, done=0. zero=1 (combinational from result). ready=1 once reset releases.
- Reset mid-operation aborts immediately. No done pulse is produced for the aborted op.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1 at an edge: latch a, b, alu_op; counter=0; carry reg=alu_op[2] (gives +1 for two's-complement subtract); result cleared to 0; go to RUN.
- RUN: ready=0. Start is ignored with no effect on the latched values.
- Each RUN cycle processes bit i=counter:
  - x = a[i]^alu_op[3]
  - y = b[i]^alu_op[2]
  - sum = x^y^c
  - cout = x&y | x&c | y&c
  - bit = alu_op[1] ? sum : (alu_op[0] ? x|y : x&y)
  - result[i] is written with bit.
  - The carry reg takes cout for every op code (flags are meaningful only for alu_op[1]=1).
- At i=WIDTH-1: carry_out<=cout, overflow<=c^cout (c = carry into MSB), go to DONE. Otherwise counter+1.
- DONE: done=1 for exactly one cycle, ready=0. Next edge goes to IDLE.
- Latency: start accepted at edge 0 → bits processed at edges 1..WIDTH → done=1 in the cycle after edge WIDTH. A new start can be accepted at edge WIDTH+2 at the earliest.
- Throughput is one op per WIDTH+2 cycles.
- result, zero, carry_out and overflow hold their values from done until the next accepted start clears them.
- Counter never wraps: it exits at WIDTH-1. CNT_W must hold WIDTH-1.
- All 16 alu_op codes are legal. Standard codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
- start held high continuously causes back-to-back ops, each accepted only in IDLE.

Test Plan:
1. WIDTH=8, ADD a=0x7F b=0x01 → done at cycle 9 after start edge, result=0x80, carry_out=0, overflow=1, zero=0; done high exactly 1 cycle.
2. WIDTH=8, SUB (0110) a=0x05 b=0x05 → result=0x00, zero=1, carry_out=1, overflow=0. Then SUB a=0x03 b=0x05 → result=0xFE, carry_out=0, zero=0.
3. WIDTH=8:
   - AND a=0xCA b=0x0F → 0x0A.
   - OR → 0xCF.
   - NOR (1100) a=0xF0 b=0x0F → 0x00, zero=1.
4. start pulsed with a=0x11 during RUN of an ADD 0x01+0x02 → ignored; result=0x03; ready stays 0 until IDLE; result holds 0x03 with start low for 5 extra cycles.
5. reset_n=0 for one edge at bit 3 of an ADD → next cycle state IDLE, ready=1, result=0, done never pulses. A fresh ADD 0xFF+0x01 → result=0x00, carry_out=1, zero=1.
6. WIDTH=32, start held high continuously with ADD 0xFFFFFFFF+0x00000001 → done every 34 cycles, result=0, carry_out=1, overflow=0.
